// File: rtl/credit_arb_pkg.sv
// rtl/credit_arb_pkg.sv - shared types and helpers for the credit pool arbiter
//
// Purpose : FSM state encoding and pointer-width helper used by
//           credit_pool_arbiter and rr_pick.
// Contents: state_t  - RUN (normal arbitration) / DRAIN (waiting for pool refill)
//           ptr_w(n) - bits needed to hold a requester index 0..n-1 (min 1)
package credit_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/credit_pool_arbiter_rr_pick.sv
// rtl/credit_pool_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose : Selects the first eligible requester scanning from i_ptr upward,
//           wrapping modulo N. No state; reusable by other arbiters.
// Ports   : i_elig  [N]  eligibility vector
//           i_ptr   [PW] requester index to start the scan from (< N)
//           o_grant [N]  one-hot grant, zero when nothing is eligible
//           o_idx   [PW] index of the granted requester (0 when none)
//           o_valid      1 when a grant was issued
module rr_pick
  import credit_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = int'(i_ptr) + k;
      if (pos >= N) pos = pos - N;
      // First hit in scan order wins; later hits are ignored.
      if (!o_valid && i_elig[pos]) begin
        o_valid      = 1'b1;
        o_grant[pos] = 1'b1;
        o_idx        = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/credit_pool_arbiter.sv
// rtl/credit_pool_arbiter.sv - shared credit pool with round-robin grant and resize
//
// Purpose : One available-credit counter shared by NREQ requesters. At most one
//           request is granted per cycle, round-robin, only when its cost fits
//           in the registered credits. Returns refill the pool; a resize drains
//           all outstanding credits, then reloads the new limit.
// Ports   : CLK, nRST                 clock, async active-low reset
//           req__ENA[NREQ]            request valid, held until granted
//           req_amt[NREQ*count_sz]    per-requester cost, slice i*count_sz
//           grant[NREQ]               one-hot grant, combinational
//           ret__ENA, ret_v           credit return
//           cfg__ENA, cfg_v, cfg__RDY new pool limit request / ready (RUN)
//           credits, limit            available credits / current pool limit
//           busy                      high while draining for a resize
//           err_overflow              sticky: a return exceeded the limit
module credit_pool_arbiter
  import credit_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int count_sz     = 10,
  parameter int INIT_CREDITS = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req__ENA,
  input  logic [NREQ*count_sz-1:0] req_amt,
  output logic [NREQ-1:0]          grant,
  input  logic                     ret__ENA,
  input  logic [count_sz-1:0]      ret_v,
  input  logic                     cfg__ENA,
  input  logic [count_sz-1:0]      cfg_v,
  output logic                     cfg__RDY,
  output logic [count_sz-1:0]      credits,
  output logic [count_sz-1:0]      limit,
  output logic                     busy,
  output logic                     err_overflow
);

  localparam int                  PW     = ptr_w(NREQ);
  localparam logic [count_sz-1:0] INIT_C = count_sz'(INIT_CREDITS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [count_sz-1:0] r_avail;
  logic [count_sz-1:0] r_limit;
  logic [count_sz-1:0] r_pend;
  logic [PW-1:0]       r_ptr;
  logic                r_err;

  logic [NREQ-1:0]     w_elig;
  logic [NREQ-1:0]     w_grant;
  logic [PW-1:0]       w_gidx;
  logic                w_gvalid;
  logic [PW-1:0]       w_ptr_nxt;
  logic [count_sz-1:0] w_gamt;
  logic [count_sz-1:0] w_ret;
  logic [count_sz:0]   w_sum;
  logic                w_ovf;
  logic [count_sz-1:0] w_avail_nxt;
  logic                w_capture;
  logic                w_reload;

  // Eligibility compares against the registered pool only; a return in the
  // same cycle is not visible until the next one.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req__ENA[i]
               && (req_amt[i*count_sz +: count_sz] <= r_avail)
               && (r_state == RUN);
    end
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  // One-hot grant lets the cost mux be a plain OR of masked slices.
  always_comb begin
    w_gamt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gamt = w_gamt | req_amt[i*count_sz +: count_sz];
    end
  end

  assign w_ptr_nxt = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_ret     = ret__ENA ? ret_v : '0;

  // One extra bit holds avail+ret; the subtraction cannot go negative
  // because a granted cost never exceeds avail.
  assign w_sum       = {1'b0, r_avail} + {1'b0, w_ret} - {1'b0, w_gamt};
  assign w_ovf       = (w_sum > {1'b0, r_limit});
  assign w_avail_nxt = w_ovf ? r_limit : w_sum[count_sz-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_reload    = 1'b0;
    case (r_state)
      RUN: begin
        if (cfg__ENA) begin
          w_state_nxt = DRAIN;
          w_capture   = 1'b1;
        end
      end
      DRAIN: begin
        // Pool is whole again once the post-return value reaches the old limit.
        if (w_avail_nxt == r_limit) begin
          w_state_nxt = RUN;
          w_reload    = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_avail <= INIT_C;
      r_limit <= INIT_C;
      r_pend  <= INIT_C;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_ovf)     r_err  <= 1'b1;
      if (w_gvalid)  r_ptr  <= w_ptr_nxt;
      if (w_capture) r_pend <= cfg_v;
      if (w_reload) begin
        r_limit <= r_pend;
        r_avail <= r_pend;
      end else begin
        r_avail <= w_avail_nxt;
      end
    end
  end

  assign grant        = w_grant;
  assign cfg__RDY     = (r_state == RUN);
  assign busy         = (r_state == DRAIN);
  assign credits      = r_avail;
  assign limit        = r_limit;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_credit_pool_arbiter.sv
// tb/tb_credit_pool_arbiter.sv - self-checking bench for credit_pool_arbiter
module tb_credit_pool_arbiter;

  localparam int NREQ = 4;
  localparam int CS   = 10;
  localparam int INIT = 16;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_ena;
  logic [NREQ*CS-1:0]   req_amt;
  logic [NREQ-1:0]      grant;
  logic                 ret_ena;
  logic [CS-1:0]        ret_v;
  logic                 cfg_ena;
  logic [CS-1:0]        cfg_v;
  logic                 cfg_rdy;
  logic [CS-1:0]        credits;
  logic [CS-1:0]        limit_o;
  logic                 busy;
  logic                 err_ovf;

  credit_pool_arbiter #(
    .NREQ         (NREQ),
    .count_sz     (CS),
    .INIT_CREDITS (INIT)
  ) dut (
    .CLK          (clk),
    .nRST         (rst_n),
    .req__ENA     (req_ena),
    .req_amt      (req_amt),
    .grant        (grant),
    .ret__ENA     (ret_ena),
    .ret_v        (ret_v),
    .cfg__ENA     (cfg_ena),
    .cfg_v        (cfg_v),
    .cfg__RDY     (cfg_rdy),
    .credits      (credits),
    .limit        (limit_o),
    .busy         (busy),
    .err_overflow (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus state
  bit en[NREQ];
  int amt[NREQ];
  bit r_en;
  int r_amt;
  bit c_en;
  int c_val;

  // reference model
  int  m_avail, m_limit, m_pend, m_ptr, m_err;
  bit  m_drain;
  int  last_g;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_avail = INIT; m_limit = INIT; m_pend = INIT;
    m_ptr = 0; m_err = 0; m_drain = 0; last_g = -1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_ena[i] = en[i];
      req_amt[i*CS +: CS] = CS'(amt[i]);
    end
    ret_ena = r_en;
    ret_v   = CS'(r_amt);
    cfg_ena = c_en;
    cfg_v   = CS'(c_val);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NREQ; i++) begin en[i] = 0; amt[i] = 0; end
    r_en = 0; r_amt = 0; c_en = 0; c_val = 0;
  endtask

  // One clock: drive, check against the model mid-cycle, advance the model.
  task automatic tick();
    int g;
    int s;
    drive();
    @(negedge clk);
    g = -1;
    if (!m_drain) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && en[i] && amt[i] <= m_avail) g = i;
      end
    end
    chk("grant",   32'(grant),   (g < 0) ? 32'd0 : (32'd1 << g));
    chk("credits", 32'(credits), 32'(m_avail));
    chk("limit",   32'(limit_o), 32'(m_limit));
    chk("busy",    32'(busy),    32'(m_drain));
    chk("cfg_rdy", 32'(cfg_rdy), 32'(!m_drain));
    chk("err",     32'(err_ovf), 32'(m_err));
    s = m_avail + (r_en ? r_amt : 0) - ((g >= 0) ? amt[g] : 0);
    if (s > m_limit) begin s = m_limit; m_err = 1; end
    if (g >= 0) m_ptr = (g + 1) % NREQ;
    if (m_drain) begin
      if (s == m_limit) begin m_limit = m_pend; s = m_pend; m_drain = 0; end
    end else if (c_en) begin
      m_drain = 1; m_pend = c_val;
    end
    m_avail = s;
    last_g  = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    drive();
    m_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: reset state
    chk("t1_credits", 32'(credits), 32'd16);
    chk("t1_limit",   32'(limit_o), 32'd16);
    chk("t1_grant",   32'(grant),   32'd0);
    chk("t1_rdy",     32'(cfg_rdy), 32'd1);
    chk("t1_busy",    32'(busy),    32'd0);
    chk("t1_err",     32'(err_ovf), 32'd0);

    // 2: four held requests of cost 2 drain the pool in rotation
    for (int i = 0; i < NREQ; i++) begin en[i] = 1; amt[i] = 2; end
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_order", 32'(last_g), 32'(k % NREQ));
      chk("t2_cred",  32'(credits), 32'(14 - 2 * k));
    end
    chk("t2_nogrant", 32'(grant), 32'd0);
    tick();
    clear_inputs();
    r_en = 1; r_amt = 16;
    tick();
    clear_inputs();

    // 3: oversized request skipped, granted after a return
    en[3] = 1; amt[3] = 13;
    tick();
    clear_inputs();
    chk("t3_avail3", 32'(credits), 32'd3);
    en[0] = 1; amt[0] = 5; en[1] = 1; amt[1] = 2;
    tick();
    chk("t3_skip", 32'(last_g), 32'd1);
    en[1] = 0; r_en = 1; r_amt = 5;
    tick();
    r_en = 0; r_amt = 0;
    drive();
    #1;
    chk("t3_req0", 32'(grant), 32'd1);
    tick();
    clear_inputs();
    r_en = 1; r_amt = 15;
    tick();
    clear_inputs();

    // 4: grant and return together, then overflowing return
    en[0] = 1; amt[0] = 6;
    tick();
    amt[0] = 4; r_en = 1; r_amt = 6;
    tick();
    clear_inputs();
    chk("t4_both", 32'(credits), 32'd12);
    r_en = 1; r_amt = 7;
    tick();
    clear_inputs();
    chk("t4_clip", 32'(credits), 32'd16);
    chk("t4_err",  32'(err_ovf), 32'd1);

    // 5: resize with outstanding credits
    en[1] = 1; amt[1] = 6;
    tick();
    clear_inputs();
    c_en = 1; c_val = 8;
    tick();
    clear_inputs();
    chk("t5_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NREQ; i++) begin en[i] = 1; amt[i] = 1; end
    drive();
    #1;
    chk("t5_block", 32'(grant), 32'd0);
    tick();
    r_en = 1; r_amt = 6;
    tick();
    clear_inputs();
    drive();
    chk("t5_limit", 32'(limit_o), 32'd8);
    chk("t5_cred",  32'(credits), 32'd8);
    chk("t5_busy0", 32'(busy),    32'd0);

    // 6: reset during DRAIN with pending requests
    en[2] = 1; amt[2] = 3;
    tick();
    clear_inputs();
    c_en = 1; c_val = 12;
    tick();
    clear_inputs();
    for (int i = 0; i < NREQ; i++) begin en[i] = 1; amt[i] = 1; end
    tick();
    chk("t6_inbusy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_busy",  32'(busy),    32'd0);
    chk("t6_rdy",   32'(cfg_rdy), 32'd1);
    chk("t6_cred",  32'(credits), 32'd16);
    chk("t6_limit", 32'(limit_o), 32'd16);
    chk("t6_err",   32'(err_ovf), 32'd0);
    chk("t6_grant", 32'(grant),   32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("t6_first", 32'(last_g), 32'd0);
    clear_inputs();

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      int outst;
      if (last_g >= 0) en[last_g] = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!en[i] && ($urandom % 2) == 0) begin
          en[i]  = 1;
          amt[i] = $urandom_range(0, 6);
        end
      end
      outst = m_limit - m_avail;
      if (outst < 0) outst = 0;
      r_en = 0; r_amt = 0;
      if (($urandom % 40) == 0) begin
        r_en = 1; r_amt = outst + $urandom_range(1, 3);
      end else if (outst > 0 && ($urandom % 3) == 0) begin
        r_en = 1; r_amt = $urandom_range(1, outst);
      end
      c_en  = (($urandom % 25) == 0);
      c_val = $urandom_range(0, 24);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
